// File: rtl/tm1637_display_ctrl.sv
// rtl/tm1637_display_ctrl.sv - TM1637 refresh sequencer feeding a byte writer
// Streams the 7-byte command/data refresh per update with a request-pending rerun.
module tm1637_display_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [15:0] digits,
  input  logic [3:0]  dots,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  input  logic        writer_busy,
  output logic        data_latch,
  output logic [7:0]  data_out,
  output logic        data_stop_bit,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

  state_t      state;
  logic [2:0]  index;
  logic [15:0] snap_digits, pend_digits;
  logic [3:0]  snap_dots, pend_dots;
  logic [2:0]  snap_brightness, pend_brightness;
  logic        snap_on, pend_on;
  logic        pending;

  logic [7:0]  next_byte;
  logic        next_stop;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    next_byte = 8'h00;
    next_stop = 1'b0;
    case (index)
      3'd0: begin next_byte = 8'h40; next_stop = 1'b1; end
      3'd1: next_byte = 8'hC0;
      3'd2: next_byte = {snap_dots[3], seg(snap_digits[15:12])};
      3'd3: next_byte = {snap_dots[2], seg(snap_digits[11:8])};
      3'd4: next_byte = {snap_dots[1], seg(snap_digits[7:4])};
      3'd5: begin next_byte = {snap_dots[0], seg(snap_digits[3:0])}; next_stop = 1'b1; end
      3'd6: begin next_byte = {4'b1000, snap_on, snap_brightness}; next_stop = 1'b1; end
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      index           <= 3'd0;
      pending         <= 1'b0;
      snap_digits     <= 16'h0000;
      snap_dots       <= 4'h0;
      snap_brightness <= 3'd0;
      snap_on         <= 1'b0;
      pend_digits     <= 16'h0000;
      pend_dots       <= 4'h0;
      pend_brightness <= 3'd0;
      pend_on         <= 1'b0;
      data_latch      <= 1'b0;
      data_out        <= 8'h00;
      data_stop_bit   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      data_latch <= 1'b0;
      done       <= 1'b0;
      // Requests arriving mid-sequence collapse into one rerun; the latest wins.
      if (update && state != S_IDLE) begin
        pending         <= 1'b1;
        pend_digits     <= digits;
        pend_dots       <= dots;
        pend_brightness <= brightness;
        pend_on         <= display_on;
      end
      case (state)
        S_IDLE: begin
          if (update) begin
            snap_digits     <= digits;
            snap_dots       <= dots;
            snap_brightness <= brightness;
            snap_on         <= display_on;
            busy            <= 1'b1;
            index           <= 3'd0;
            state           <= S_SEND;
          end
        end
        S_SEND: begin
          data_out      <= next_byte;
          data_stop_bit <= next_stop;
          data_latch    <= 1'b1;
          state         <= S_GAP;
        end
        S_GAP: state <= S_WAIT;
        S_WAIT: begin
          if (!writer_busy) begin
            if (index != 3'd6) begin
              index <= index + 3'd1;
              state <= S_SEND;
            end else begin
              done <= 1'b1;
              if (update) begin
                snap_digits     <= digits;
                snap_dots       <= dots;
                snap_brightness <= brightness;
                snap_on         <= display_on;
                pending         <= 1'b0;
                index           <= 3'd0;
                state           <= S_SEND;
              end else if (pending) begin
                snap_digits     <= pend_digits;
                snap_dots       <= pend_dots;
                snap_brightness <= pend_brightness;
                snap_on         <= pend_on;
                pending         <= 1'b0;
                index           <= 3'd0;
                state           <= S_SEND;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tm1637_display_ctrl.md
# tm1637_display_ctrl

Command sequencer that sits directly upstream of the TM1637 byte writer. It turns a four-digit hex value, decimal points, brightness and on/off into the TM1637 command stream. It encodes each digit to seven-segment and hands bytes one at a time to the writer over its latch/busy handshake. Host logic pulses `update`; the block streams seven bytes per refresh and pulses `done`.

## Interface
- No parameters; the byte sequence and segment map are fixed.
- `clk` input 1: system clock; the writer runs on the same clock.
- `rst` input 1: reset, synchronous, active-low; `rst == 0` at a rising edge resets.
- `update` input 1: one-cycle refresh request; inputs are sampled on the same edge.
- `digits` input 16: four hex nibbles; `[15:12]` is the leftmost digit (address 0xC0), `[3:0]` the rightmost (0xC3).
- `dots` input 4: `dots[3]` is the leftmost DP/colon, `dots[0]` the rightmost.
- `brightness` input 3: pulse-width level 0..7.
- `display_on` input 1: 1 turns the display on.
- `writer_busy` input 1: the writer's `busy`.
- `data_latch` output 1: one-cycle byte strobe to the writer.
- `data_out` output 8: byte to the writer.
- `data_stop_bit` output 1: 1 requests a stop condition after this byte.
- `busy` output 1: a sequence is in progress.
- `done` output 1: one-cycle pulse when a sequence completes.

## Operation
- Reset values: `data_latch`=0, `data_out`=0x00, `data_stop_bit`=0, `busy`=0, `done`=0, state S_IDLE, byte index 0, pending flag 0.
- Byte sequence, index 0..6, with (byte, stop):
  - 0: (0x40, 1)
  - 1: (0xC0, 0)
  - 2: (seg(`digits[15:12]`) | `dots[3]`<<7, 0)
  - 3: (seg(`digits[11:8]`) | `dots[2]`<<7, 0)
  - 4: (seg(`digits[7:4]`) | `dots[1]`<<7, 0)
  - 5: (seg(`digits[3:0]`) | `dots[0]`<<7, 1)
  - 6: (0x80 | `display_on`<<3 | `brightness`, 1)
- Segment map: bit0=a … bit6=g.
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Snapshot: `digits`, `dots`, `brightness` and `display_on` are registered when a sequence starts. Later input changes do not affect the bytes in flight.
- States:
  - S_IDLE: on `update`, snapshot, `busy`←1, index←0, go to S_SEND.
  - S_SEND: drive `data_out`/`data_stop_bit` for the current index, `data_latch`←1, go to S_GAP.
  - S_GAP: `data_latch`←0, go to S_WAIT. This one cycle lets the writer's registered `busy` rise.
  - S_WAIT: hold while `writer_busy`=1. On `writer_busy`=0:
    - if index<6: index+1, go to S_SEND.
    - if index=6: `done`←1, then restart or return to idle (below).
  - Restart at index 6: if `update` or pending is set, index←0, clear pending, go to S_SEND. Snapshot is taken from the live inputs if `update` is high this cycle, else from the pending registers.
  - Otherwise at index 6: `busy`←0, go to S_IDLE.
- `update` in any non-idle state: pending←1 and the inputs are captured into pending registers. The last request wins; multiple requests collapse into one rerun.
- `data_out` and `data_stop_bit` hold their last values between strobes.
- `writer_busy` stuck high: wait indefinitely; there is no timeout.
- Reset mid-sequence: immediate return to reset values; the partial sequence and pending request are discarded.
- Unreachable state encodings go to S_IDLE.

## Timing
- `update` sampled at edge E (idle) → `busy`=1 after E; `data_latch`=1 for exactly the cycle after E+1, with `data_out`/`data_stop_bit` valid in that cycle.
- `data_latch` is never high for more than one cycle. Consecutive strobes are at least 3 cycles apart: SEND, GAP, then ≥1 WAIT.
- For an idle writer that clears `busy` k cycles after its latch, the next strobe follows after the WAIT that sees `writer_busy`=0, then S_SEND.
- `done` is high for one cycle after the edge at which S_WAIT sees `writer_busy`=0 at index 6. `busy` drops on that same edge unless a restart occurs. On restart, `busy` stays 1 and `done` still pulses.
- `update` while in S_IDLE is never lost, and neither is `update` on the completion edge.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `update` toggling → all outputs 0; no `data_latch` until after release.
- Basic: `digits`=0x1234, `dots`=0, `brightness`=7, `display_on`=1, writer model with busy of 20 cycles → strobes are 40/1, C0/0, 06/0, 5B/0, 4F/0, 66/1, 8F/1 in order; one `done`; `busy` falls with `done`.
- Encoding: `digits`=0xABCD, `dots`=0b0100, `display_on`=0, `brightness`=3 → 77, FC, 39, 5E; final byte 0x83.
- Snapshot and pending: start with 0x0000, change inputs to 0xFFFF, pulse `update` twice during byte 3 → first sequence all 3F; second sequence (no idle gap) all 71; exactly two `done` pulses; `busy` continuous.
- Completion collision: `update` on the exact completion edge → immediate rerun with that cycle's inputs.
- Reset mid-sequence: assert `rst`=0 during S_WAIT of byte 4 → outputs return to reset values the next edge; no further strobes; no `done`.
